// File: rtl/bsram_save_sequencer.sv
// BSRAM save/load sequencer: walks save-file sectors 0..ram_mask[23:9]
// over the hps_io sector interface for manual load/save, post-download
// auto-load and dirty-tracked autosave, with a per-ack-edge timeout.
module bsram_save_sequencer #(
  parameter int unsigned AUTOSAVE_CYCLES = 21477270,
  parameter int unsigned TIMEOUT_CYCLES  = 2147727
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic [23:0] ram_mask,
  input  logic        rom_loaded,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        bsram_wr,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_loading,
  output logic        busy,
  output logic        dirty,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t      state, state_nxt;
  logic        op_load;
  logic [31:0] auto_cnt, tmo_cnt;

  // two registered copies per input: d1 is the sampled value, d2 the one before
  logic load_d1, load_d2, save_d1, save_d2, rom_d1, rom_d2, ack_d1, ack_d2;

  logic load_rise, save_rise, rom_fall;
  logic ack_rise, ack_fall, ack_edge;
  logic mask_ok, last_lba, auto_run, auto_hit;
  logic start_load, start_save, start, tmo_hit, done;

  assign mask_ok    = |ram_mask;
  assign last_lba   = (sd_lba == {17'b0, ram_mask[23:9]});
  assign load_rise  = load_d1 & ~load_d2 & bk_ena;
  assign save_rise  = save_d1 & ~save_d2 & bk_ena;
  assign rom_fall   = ~rom_d1 & rom_d2 & bk_ena;
  assign ack_rise   = ack_d1 & ~ack_d2;
  assign ack_fall   = ~ack_d1 & ack_d2;
  assign ack_edge   = ack_d1 ^ ack_d2;
  assign auto_run   = (state == IDLE) & dirty & autosave_en & bk_ena;
  assign auto_hit   = auto_run & (auto_cnt == AUTOSAVE_CYCLES - 32'd1);
  // an empty mask means no RAM to move, so every trigger is swallowed
  assign start_load = (load_rise | rom_fall) & mask_ok;
  assign start_save = (save_rise | auto_hit) & mask_ok;
  assign start      = (state == IDLE) & (start_load | start_save);
  // an ack edge in the same cycle wins over the timeout
  assign tmo_hit    = (state != IDLE) & ~ack_edge & (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
  assign done       = (state == XFER) & ack_fall & last_lba;

  // state register
  always_ff @(posedge clk_sys) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_load | start_save) state_nxt = REQ;
      REQ:     if (ack_rise) state_nxt = XFER;
               else if (tmo_hit) state_nxt = IDLE;
      XFER:    if (ack_fall) state_nxt = last_lba ? IDLE : REQ;
               else if (tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state and the latched operation type
  always_comb begin
    busy       = (state != IDLE);
    bk_loading = busy & op_load;
    sd_rd      = (state == REQ) & op_load;
    sd_wr      = (state == REQ) & ~op_load;
  end

  // edge registers, sector index, counters and dirty/err flags
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      load_d1  <= load_req;   load_d2 <= load_req;
      save_d1  <= save_req;   save_d2 <= save_req;
      rom_d1   <= rom_loaded; rom_d2  <= rom_loaded;
      ack_d1   <= sd_ack;     ack_d2  <= sd_ack;
      sd_lba   <= 32'd0;
      op_load  <= 1'b0;
      auto_cnt <= 32'd0;
      tmo_cnt  <= 32'd0;
      dirty    <= 1'b0;
      err      <= 1'b0;
    end else begin
      load_d1 <= load_req;   load_d2 <= load_d1;
      save_d1 <= save_req;   save_d2 <= save_d1;
      rom_d1  <= rom_loaded; rom_d2  <= rom_d1;
      ack_d1  <= sd_ack;     ack_d2  <= ack_d1;

      if (start) begin
        sd_lba  <= 32'd0;
        op_load <= start_load;
      end else if ((state == XFER) && ack_fall && !last_lba) begin
        sd_lba <= sd_lba + 32'd1;
      end

      err      <= tmo_hit;
      tmo_cnt  <= (busy && !ack_edge && !tmo_hit) ? tmo_cnt + 32'd1 : 32'd0;
      auto_cnt <= (auto_run && !bsram_wr && !start) ? auto_cnt + 32'd1 : 32'd0;

      // save start clears dirty unless a write lands in that same cycle;
      // writes during a load come from the held-in-reset core and are ignored
      if (start && !start_load)        dirty <= bsram_wr;
      else if (tmo_hit && !op_load)    dirty <= 1'b1;
      else if (done && op_load)        dirty <= 1'b0;
      else if (bsram_wr && !bk_loading) dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsram_save_sequencer.sv
// Scoreboard bench for bsram_save_sequencer: expected sector requests are
// queued when a trigger is issued; a monitor pops them at each request rise.
module tb_bsram_save_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset, bk_ena, rom_loaded, load_req, save_req, autosave_en, bsram_wr, sd_ack;
  logic [23:0] ram_mask;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_loading, busy, dirty, err;

  always #5 clk_sys = ~clk_sys;

  bsram_save_sequencer #(.AUTOSAVE_CYCLES(100), .TIMEOUT_CYCLES(64)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .ram_mask(ram_mask),
    .rom_loaded(rom_loaded), .load_req(load_req), .save_req(save_req),
    .autosave_en(autosave_en), .bsram_wr(bsram_wr), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_loading(bk_loading),
    .busy(busy), .dirty(dirty), .err(err)
  );

  typedef struct packed { logic wr; logic [31:0] lba; } xfer_t;
  xfer_t exp_q[$];
  xfer_t mon_e;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int req_count = 0, err_count = 0, busy_cnt = 0;
  int ack_fall_cyc = 0;
  bit ack_en;
  bit req_prev = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // reference: a nonzero mask covers sectors 0 .. mask/512
  task automatic push_seq(bit wr, logic [23:0] mask);
    if (mask != 0)
      for (int i = 0; i <= int'(mask / 512); i++) exp_q.push_back('{wr, 32'(i)});
  endtask

  task automatic wait_busy(bit val, int bound, string name);
    int n = 0;
    while (busy !== val && n < bound) begin @(negedge clk_sys); n++; end
    chk(name, {31'b0, busy}, {31'b0, val});
  endtask

  task automatic wait_req(bit wr, logic [31:0] lba, int bound, string name);
    int n = 0;
    while (!((wr ? sd_wr : sd_rd) === 1'b1 && sd_lba === lba) && n < bound) begin
      @(negedge clk_sys); n++;
    end
    chk(name, {31'b0, (wr ? sd_wr : sd_rd)}, 32'd1);
  endtask

  task automatic rise_load();
    load_req = 1'b0; tick(); tick(); load_req = 1'b1; tick();
  endtask

  task automatic rise_save();
    save_req = 1'b0; tick(); tick(); save_req = 1'b1; tick();
  endtask

  task automatic wr_pulse();
    bsram_wr = 1'b1; tick(); bsram_wr = 1'b0;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_lba"}, sd_lba, 32'd0);
    chk({tag, "_rd"}, {31'b0, sd_rd}, 32'd0);
    chk({tag, "_wr"}, {31'b0, sd_wr}, 32'd0);
    chk({tag, "_bk_loading"}, {31'b0, bk_loading}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_dirty"}, {31'b0, dirty}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  // hps_io model: random 0..3 cycle latency, then a 10-cycle ack
  initial begin
    sd_ack = 1'b0;
    forever begin
      tick();
      if (ack_en && reset && (sd_rd || sd_wr) && !sd_ack) begin
        int d;
        d = $urandom_range(0, 3);
        repeat (d) tick();
        sd_ack = 1'b1;
        repeat (10) tick();
        sd_ack = 1'b0;
        ack_fall_cyc = cyc;
      end
    end
  end

  // monitor: score every request rise against the expected queue
  always @(negedge clk_sys) begin
    if (reset) begin
      if ((sd_rd || sd_wr) && !req_prev) begin
        req_count++;
        chk("rd_wr_exclusive", {31'b0, sd_rd & sd_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=%0h expected no request", sd_rd, sd_wr, sd_lba);
        end else begin
          mon_e = exp_q.pop_front();
          chk("req_kind_wr", {31'b0, sd_wr}, {31'b0, mon_e.wr});
          chk("req_lba", sd_lba, mon_e.lba);
          if (!mon_e.wr) chk("bk_loading_in_load", {31'b0, bk_loading}, 32'd1);
        end
      end
      req_prev <= sd_rd | sd_wr;
      if (err) err_count++;
      if (busy) busy_cnt++;
    end else begin
      req_prev <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, ec, bc, t0, t2, n;
    logic [23:0] m;
    bit op;
    reset = 1'b0; bk_ena = 1'b1; ram_mask = 24'h1FFF; rom_loaded = 1'b1;
    load_req = 1'b0; save_req = 1'b0; autosave_en = 1'b0; bsram_wr = 1'b0;
    ack_en = 1'b1;
    repeat (3) tick();
    @(negedge clk_sys);
    chk_reset_outs("reset");
    tick(); reset = 1'b1; tick();

    // auto-load after ROM download: 16 reads
    push_seq(1'b0, 24'h1FFF);
    rom_loaded = 1'b0;
    wait_busy(1'b1, 20, "autoload_busy");
    wait_busy(1'b0, 2000, "autoload_done");
    chk("autoload_done_latency", cyc - ack_fall_cyc, 32'd2);
    chk("autoload_bk_loading_end", {31'b0, bk_loading}, 32'd0);
    chk("autoload_dirty", {31'b0, dirty}, 32'd0);
    chk("autoload_drained", exp_q.size(), 32'd0);

    // manual save with a write during sector 2
    ram_mask = 24'h7FF; tick();
    wr_pulse(); tick();
    chk("save_dirty_before", {31'b0, dirty}, 32'd1);
    push_seq(1'b1, 24'h7FF);
    rise_save();
    wait_busy(1'b1, 20, "save_busy");
    chk("save_dirty_cleared", {31'b0, dirty}, 32'd0);
    wait_req(1'b1, 32'd2, 500, "save_sector2");
    tick(); wr_pulse();
    wait_busy(1'b0, 1000, "save_done");
    chk("save_dirty_after_write", {31'b0, dirty}, 32'd1);
    chk("save_drained", exp_q.size(), 32'd0);

    // randomized load/save over random mask sizes
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 6);
      m = 24'(((n - 1) * 512) + $urandom_range(1, 511));
      op = 1'($urandom_range(0, 1));
      ram_mask = m;
      push_seq(op, m);
      if (op) rise_save(); else rise_load();
      wait_busy(1'b1, 20, "rand_busy");
      wait_busy(1'b0, 2000, "rand_done");
      chk("rand_drained", exp_q.size(), 32'd0);
      chk("rand_dirty", {31'b0, dirty}, 32'd0);
    end

    // autosave: writes 50 cycles apart, save ~100 cycles after the last
    ram_mask = 24'h3FF;
    push_seq(1'b1, 24'h3FF);
    autosave_en = 1'b1;
    wr_pulse();
    repeat (49) tick();
    bsram_wr = 1'b1; t2 = cyc; tick(); bsram_wr = 1'b0;
    n = 0;
    while (sd_wr !== 1'b1 && n < 300) begin @(negedge clk_sys); n++; end
    t0 = cyc - t2;
    n_chk++;
    if (t0 < 98 || t0 > 102) begin
      n_fail++;
      $display("FAIL autosave_start: got %0d cycles after last write, expected 98..102", t0);
    end
    wait_busy(1'b0, 1000, "autosave_done");
    chk("autosave_drained", exp_q.size(), 32'd0);
    chk("autosave_dirty", {31'b0, dirty}, 32'd0);
    autosave_en = 1'b0;
    wr_pulse();
    rc = req_count;
    repeat (300) tick();
    chk("no_autosave_when_disabled", req_count, rc);
    chk("no_autosave_dirty", {31'b0, dirty}, 32'd1);

    // priority: load wins; a save rise during the load is dropped
    ram_mask = 24'h5FF;
    push_seq(1'b0, 24'h5FF);
    load_req = 1'b0; save_req = 1'b0; tick(); tick();
    load_req = 1'b1; save_req = 1'b1; tick();
    wait_req(1'b0, 32'd1, 500, "prio_load_sector1");
    save_req = 1'b0; tick(); tick(); save_req = 1'b1; tick();
    wait_busy(1'b0, 1000, "prio_done");
    rc = req_count;
    repeat (30) tick();
    chk("prio_save_dropped", req_count, rc);
    chk("prio_drained", exp_q.size(), 32'd0);
    chk("prio_dirty", {31'b0, dirty}, 32'd0);

    // timeout: host never acks
    ack_en = 1'b0;
    ram_mask = 24'h7FF;
    wr_pulse();
    exp_q.push_back('{1'b1, 32'd0});
    ec = err_count;
    rise_save();
    n = 0;
    while (sd_wr !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
    t0 = cyc;
    chk("tmo_dirty_during", {31'b0, dirty}, 32'd0);
    n = 0;
    while (sd_wr !== 1'b0 && n < 200) begin @(negedge clk_sys); n++; end
    chk("tmo_wr_duration", cyc - t0, 32'd64);
    repeat (5) tick();
    chk("tmo_err_pulses", err_count - ec, 32'd1);
    chk("tmo_dirty_after", {31'b0, dirty}, 32'd1);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_drained", exp_q.size(), 32'd0);
    ack_en = 1'b1;

    // reset during LBA 3 of a load
    ram_mask = 24'h1FFF;
    push_seq(1'b0, 24'h1FFF);
    rise_load();
    wait_req(1'b0, 32'd3, 500, "rstmid_sector3");
    tick(); reset = 1'b0; tick();
    @(negedge clk_sys);
    chk_reset_outs("rstmid");
    tick(); reset = 1'b1;
    exp_q.delete();
    repeat (20) tick();

    // small RAM: single sector
    ram_mask = 24'h0FF;
    push_seq(1'b0, 24'h0FF);
    rc = req_count;
    rise_load();
    wait_busy(1'b1, 20, "small_busy");
    wait_busy(1'b0, 500, "small_done");
    chk("small_one_sector", req_count - rc, 32'd1);
    chk("small_drained", exp_q.size(), 32'd0);

    // zero mask: triggers ignored
    ram_mask = 24'h0;
    rc = req_count; bc = busy_cnt;
    rise_load(); rise_save();
    repeat (30) tick();
    chk("zero_mask_busy", busy_cnt - bc, 32'd0);
    chk("zero_mask_reqs", req_count - rc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
